lbp_host: RTL

LBP_HOST -- requirements
Module: lbp_host

---
 rtl/lbp_pkg.sv | 14 +
 rtl/lbp_if.sv | 40 ++++
 rtl/lbp_ram.sv | 21 ++
 rtl/lbp_host.sv | 96 +++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared constants and types for the LBP host block.
package lbp_pkg;

  localparam int IMG_DIM = 128;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } host_state_e;

endpackage

// File: rtl/lbp_if.sv
// Bus between the LBP host (slave modport) and the engine/loader side (master modport).
//
// Handshake semantics: an image-load beat transfers on a rising edge where
// load_valid && load_ready; load_ready is high only while loading.  gray_req
// and lbp_valid carry no ready: the host accepts them in every RUN cycle and
// treats them as protocol errors in any other state.  gray_data and rd_data
// are combinational views of the addressed memory word.
interface lbp_if #(
  parameter int ADDR_W = lbp_pkg::ADDR_W,
  parameter int DATA_W = lbp_pkg::DATA_W
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [DATA_W-1:0] gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [DATA_W-1:0] lbp_data;
  logic              finish;
  logic              done;
  logic [ADDR_W:0]   wr_count;
  logic              err;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport slave (
    input  load_valid, load_data, gray_req, gray_addr,
           lbp_valid, lbp_addr, lbp_data, finish, rd_addr,
    output load_ready, gray_ready, gray_data, done, wr_count, err, rd_data
  );

  modport master (
    output load_valid, load_data, gray_req, gray_addr,
           lbp_valid, lbp_addr, lbp_data, finish, rd_addr,
    input  load_ready, gray_ready, gray_data, done, wr_count, err, rd_data
  );
endinterface

// File: rtl/lbp_ram.sv
// Simple RAM: one synchronous write port, one asynchronous read port, no reset.
module lbp_ram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Write port: contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/lbp_host.sv
// LBP host: loads a gray image, serves engine reads, stores LBP results.
module lbp_host #(
  parameter int ADDR_W = lbp_pkg::ADDR_W,
  parameter int DATA_W = lbp_pkg::DATA_W
) (
  input  logic       clk,
  input  logic       reset,
  lbp_if.slave       bus,
  output logic [1:0] state_o
);
  import lbp_pkg::*;

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;
  localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

  host_state_e       state_q;
  logic [ADDR_W-1:0] load_ptr_q;
  logic [ADDR_W:0]   wr_count_q;
  logic              gray_ready_q;
  logic              done_q;
  logic              err_q;

  logic              gray_we;
  logic              res_we;
  logic              err_event;
  logic [DATA_W-1:0] gray_rdata;

  // Memory writes only in their own state and never under reset, so an
  // erroneous beat or write cannot touch either memory.
  assign gray_we   = !reset && (state_q == LOAD) && bus.load_valid;
  assign res_we    = !reset && (state_q == RUN)  && bus.lbp_valid;
  assign err_event = ((bus.gray_req || bus.lbp_valid) && (state_q != RUN)) ||
                     (bus.load_valid && (state_q != LOAD));

  lbp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) gray_mem (
    .clk     (clk),
    .we_i    (gray_we),
    .waddr_i (load_ptr_q),
    .wdata_i (bus.load_data),
    .raddr_i (bus.gray_addr),
    .rdata_o (gray_rdata)
  );

  lbp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) res_mem (
    .clk     (clk),
    .we_i    (res_we),
    .waddr_i (bus.lbp_addr),
    .wdata_i (bus.lbp_data),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data)
  );

  // Host FSM with its registered status outputs and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      load_ptr_q   <= '0;
      wr_count_q   <= '0;
      gray_ready_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (err_event) err_q <= 1'b1;
      case (state_q)
        LOAD: begin
          if (bus.load_valid) begin
            load_ptr_q <= load_ptr_q + 1'b1;  // wraps to 0 after the last pixel
            if (load_ptr_q == PTR_LAST) begin
              state_q      <= RUN;
              gray_ready_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.lbp_valid && (wr_count_q != CNT_MAX)) wr_count_q <= wr_count_q + 1'b1;
          // A write in the same cycle as finish still lands (res_we above).
          if (bus.finish) begin
            state_q      <= DONE;
            gray_ready_q <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        DONE: ;  // held until reset; finish is ignored here
        default: state_q <= LOAD;
      endcase
    end
  end

  assign bus.load_ready = (state_q == LOAD);
  assign bus.gray_ready = gray_ready_q;
  assign bus.gray_data  = ((state_q == RUN) && bus.gray_req) ? gray_rdata : '0;
  assign bus.done       = done_q;
  assign bus.wr_count   = wr_count_q;
  assign bus.err        = err_q;
  assign state_o        = state_q;
endmodule
